ub_act_feeder: RTL

Activation feeder on the read side of the unified buffer. It fetches one 2x2 activation tile through the buffer's `load_input`/`addr` read port and captures the registered tile. It then streams the tile, diagonally skewed, into the two rows of the 2x2 systolic array, and reports completion to the top-level controller. The unified buffer is written by the accumulators; this block is its consumer toward the array.

---
 rtl/tpu_pkg.sv | 17 +
 rtl/ub_act_feeder.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/tpu_pkg.sv
// Shared constants and the activation-feeder state type for the TPU datapath.
package tpu_pkg;

  localparam int DATA_W   = 8;
  localparam int ADDR_W   = 13;
  localparam int UB_DEPTH = 64;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    CAP,
    S0,
    S1,
    S2
  } feeder_state_t;

endpackage

// File: rtl/ub_act_feeder.sv
// ub_act_feeder: fetches one 2x2 activation tile from the unified buffer and
// streams it diagonally skewed into the two rows of the 2x2 systolic array.
// Optional start-address bounds check: define UB_FEEDER_BOUNDS_CHECK_EN.
module ub_act_feeder
  import tpu_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              stall,
  input  logic [DATA_W-1:0] ub_in_00,
  input  logic [DATA_W-1:0] ub_in_01,
  input  logic [DATA_W-1:0] ub_in_10,
  input  logic [DATA_W-1:0] ub_in_11,
  output logic              ub_load_input,
  output logic [ADDR_W-1:0] ub_addr,
  output logic [DATA_W-1:0] act_row0,
  output logic [DATA_W-1:0] act_row1,
  output logic              act_valid0,
  output logic              act_valid1,
  output logic              busy,
  output logic              done,
  output logic              err
);

  feeder_state_t     r_state;
  logic              r_load;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_row0;
  logic [DATA_W-1:0] r_row1;
  logic              r_valid0;
  logic              r_valid1;
  logic              r_busy;
  logic              r_done;
  // a00 has no register of its own: it goes straight into r_row0 at the end
  // of CAP so that row 0 is valid in the first S0 cycle.
  logic [DATA_W-1:0] r_a01;
  logic [DATA_W-1:0] r_a10;
  logic [DATA_W-1:0] r_a11;

`ifdef UB_FEEDER_BOUNDS_CHECK_EN
  logic              r_err;
  logic [ADDR_W:0]   w_last_addr;
  logic              w_start_ok;

  // Last word of the tile must lie inside the buffer.
  always_comb begin
    w_last_addr = {1'b0, base_addr} + (ADDR_W+1)'(3);
    w_start_ok  = (w_last_addr < (ADDR_W+1)'(UB_DEPTH));
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

  // Tile fetch and skewed streaming FSM; all outputs registered per state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_load   <= 1'b0;
      r_addr   <= '0;
      r_row0   <= '0;
      r_row1   <= '0;
      r_valid0 <= 1'b0;
      r_valid1 <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_a01    <= '0;
      r_a10    <= '0;
      r_a11    <= '0;
`ifdef UB_FEEDER_BOUNDS_CHECK_EN
      r_err    <= 1'b0;
`endif
    end else begin
      r_load <= 1'b0;
      r_done <= 1'b0;
`ifdef UB_FEEDER_BOUNDS_CHECK_EN
      r_err  <= 1'b0;
`endif
      unique case (r_state)
        IDLE: begin
          if (start) begin
`ifdef UB_FEEDER_BOUNDS_CHECK_EN
            if (w_start_ok) begin
              r_state <= REQ;
              r_load  <= 1'b1;
              r_addr  <= base_addr;
              r_busy  <= 1'b1;
            end else begin
              r_err   <= 1'b1;
            end
`else
            r_state <= REQ;
            r_load  <= 1'b1;
            r_addr  <= base_addr;
            r_busy  <= 1'b1;
`endif
          end
        end
        REQ: begin
          r_state <= CAP;
        end
        CAP: begin
          r_a01    <= ub_in_01;
          r_a10    <= ub_in_10;
          r_a11    <= ub_in_11;
          r_row0   <= ub_in_00;
          r_valid0 <= 1'b1;
          r_state  <= S0;
        end
        S0: begin
          if (!stall) begin
            r_row0   <= r_a01;
            r_row1   <= r_a10;
            r_valid1 <= 1'b1;
            r_state  <= S1;
          end
        end
        S1: begin
          if (!stall) begin
            r_row0   <= '0;
            r_valid0 <= 1'b0;
            r_row1   <= r_a11;
            r_state  <= S2;
          end
        end
        S2: begin
          if (!stall) begin
            r_row1   <= '0;
            r_valid1 <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_state  <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign ub_load_input = r_load;
  assign ub_addr       = r_addr;
  assign act_row0      = r_row0;
  assign act_row1      = r_row1;
  assign act_valid0    = r_valid0;
  assign act_valid1    = r_valid1;
  assign busy          = r_busy;
  assign done          = r_done;

endmodule
